// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and constants for the shift sequencer
package shift_seq_pkg;
    localparam int NUM_STAGES = 5;
    localparam int DATA_W     = 32;
    localparam int AMT_W      = 5;
    localparam logic SHR = 1'b0;
    localparam logic ROR = 1'b1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/shift_stage_var.sv
// shift_stage_var: shift or rotate x right by 2^k in a single combinational stage
module shift_stage_var
    import shift_seq_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [2:0]        k,
    input  logic              rot,
    output logic [DATA_W-1:0] y
);
    logic [5:0]          d;
    logic [2*DATA_W-1:0] w;
    // the upper copy of x supplies the wrapped bits; zero for a logical shift
    always_comb begin
        d = 6'd1 << k;
        w = {rot ? x : {DATA_W{1'b0}}, x} >> d;
        y = w[DATA_W-1:0];
    end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 32-bit shift/rotate right, one power-of-two stage per clock
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_shift_rot,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d, stage_y;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic              mode_q, mode_d;
    logic [2:0]        k_q, k_d, hsb, k_sel;

    always_comb begin
        hsb = '0;
        for (int i = 0; i < AMT_W; i++)
            if (amt_q[i]) hsb = 3'(i);
    end

    assign k_sel = EARLY_EXIT ? hsb : k_q;

    shift_stage_var u_stage (
        .x   (data_q),
        .k   (k_sel),
        .rot (mode_q),
        .y   (stage_y)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        amt_d   = amt_q;
        mode_d  = mode_q;
        k_d     = k_q;
        case (state_q)
            IDLE: if (in_valid && !flush) begin
                data_d  = in_data;
                amt_d   = in_amt;
                mode_d  = in_shift_rot;
                k_d     = 3'(NUM_STAGES - 1);
                state_d = (EARLY_EXIT && in_amt == '0) ? DONE : RUN;
            end
            RUN: if (EARLY_EXIT) begin
                data_d  = stage_y;
                amt_d   = amt_q & ~(5'd1 << hsb);
                state_d = (amt_d == '0) ? DONE : RUN;
            end else begin
                data_d  = amt_q[k_q] ? stage_y : data_q;
                k_d     = k_q - 3'd1;
                state_d = (k_q == 3'd0) ? DONE : RUN;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        // abort wins over everything, including a same-cycle handshake
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= SHR;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_valid ? data_q : '0;
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller for the 32-bit logical-shift-right / rotate-right datapath.
- Accepts one operation (data, 5-bit amount, shift/rotate select) over a valid/ready handshake.
- Applies one power-of-two stage (16, 8, 4, 2, 1) per clock, instead of five cascaded stages in a single cycle.
- Sits between the ALU issue logic and the writeback mux, and holds the result until the consumer accepts it.

Parameters:
- EARLY_EXIT, 1: 1 = skip stages whose amount bit is 0; 0 = always run all 5 stages.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort of any in-flight operation.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation (high only in IDLE).
- in_data  input  32  operand x.
- in_amt  input  5  shift/rotate distance r, 0..31.
- in_shift_rot  input  1  0 = logical shift right (zero fill); 1 = rotate right.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  32  result y.
- busy  output  1  state is RUN or DONE.

Behaviour:
- Reset (async, rst high):
  - state = IDLE; data_q, amt_q, mode_q = 0.
  - out_valid = 0, out_data = 0, busy = 0.
  - in_ready forced 0 while rst is high; 1 from the first cycle after release.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - Accept when in_valid & in_ready & ~flush: load data_q = in_data, amt_q = in_amt, mode_q = in_shift_rot.
  - Next state, EARLY_EXIT=1: DONE if in_amt==0, else RUN.
  - Next state, EARLY_EXIT=0: RUN, with stage counter k = 4.
- RUN, EARLY_EXIT=1:
  - Each cycle, k = index of the highest set bit of amt_q.
  - data_q <= stage(data_q, k); clear bit k of amt_q.
  - Go to DONE when the updated amt_q is 0.
- RUN, EARLY_EXIT=0:
  - Each cycle, data_q <= amt_q[k] ? stage(data_q, k) : data_q; k decrements from 4 to 0.
  - Go to DONE after k = 0 is processed.
- Stage(x, k) with d = 2^k:
  - y[i] = x[i+d] for i < 32-d.
  - For i >= 32-d: y[i] = mode_q ? x[i+d-32] : 0.
- DONE:
  - out_valid = 1; out_data = data_q, held stable while out_ready is low.
  - out_valid & out_ready moves to IDLE; out_valid is low the next cycle.
- Latency: accept in cycle C0 gives the first out_valid in cycle:
  - C0+1+popcount(in_amt) when EARLY_EXIT=1 (amt 0 gives C0+1).
  - C0+6 always when EARLY_EXIT=0.
- Throughput: one operation per (latency + 1) cycles minimum; no accept while RUN or DONE.
- flush (any state):
  - Next state IDLE; out_valid low the next cycle.
  - A result in DONE is discarded even if out_ready is high in the same cycle.
  - flush together with in_valid in IDLE: no accept.
- Reset mid-operation: all outputs clear immediately (asynchronous); no result is produced.
- Amount field is 5 bits, so no out-of-range values exist. Rotate by 0 and shift by 0 both return in_data unchanged.
- out_data is registered; it is not a combinational path from in_data.

Decomposition:
- Package shift_seq_pkg:
  - State enum {IDLE, RUN, DONE}.
  - NUM_STAGES = 5, DATA_W = 32, AMT_W = 5.
  - Mode constants SHR = 0, ROR = 1.
- Sub-module shift_stage_var (combinational):
  - Inputs x[31:0], k[2:0], rot.
  - Output: x shifted/rotated right by 2^k.
  - Instantiated once and shared across all RUN cycles.
- Highest-set-bit encoder stays inline in the FSM.

Test Plan:
1. Shift, x=0xDEADBEEF, amt=16, EARLY_EXIT=1 -> out_data=0x0000DEAD; out_valid in C0+2.
2. Rotate, x=0xDEADBEEF, amt=16 -> 0xBEEFDEAD. Rotate, x=0x80000001, amt=31 -> 0x00000003; out_valid in C0+6.
3. amt=0, x=0x12345678, shift and rotate -> 0x12345678; out_valid in C0+1 (EARLY_EXIT=1) and C0+6 (EARLY_EXIT=0).
4. Backpressure: shift x=0xF0000000, amt=5, out_ready low 3 cycles -> out_data stable at 0x07800000, in_ready=0, new in_valid ignored. Raise out_ready -> IDLE next cycle, then new accept.
5. flush asserted in the 2nd RUN cycle of rotate amt=31 -> IDLE next cycle, no out_valid pulse. Next op (shift 0x00000100, amt=8) -> 0x00000001.
6. Async rst pulse mid-RUN (between clock edges) -> out_valid, busy, out_data = 0 immediately. After release in_ready=1 and a fresh op completes correctly.
